// File: rtl/router_tbl_arbiter.sv
// Shares the single-port destination-IP table between the lookup engine and host register access.
// Statistics counters exist only when TBL_ARB_STATS_EN is defined; otherwise both ports read 0.
module router_tbl_arbiter #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_WIDTH     = 5,
  parameter int STARVE_LIMIT       = 8
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] reset,
  input  logic                          tbl_rd_req,
  input  logic                          tbl_wr_req,
  input  logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
  input  logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  output logic                          tbl_rd_ack,
  output logic                          tbl_wr_ack,
  input  logic                          lkp_req,
  input  logic [TBL_ADDR_WIDTH-1:0]     lkp_addr,
  output logic                          lkp_gnt,
  output logic [C_S_AXI_DATA_WIDTH-1:0] lkp_data,
  output logic                          lkp_valid,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [TBL_ADDR_WIDTH-1:0]     mem_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] mem_wdata,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mem_rdata,
  output logic [C_S_AXI_DATA_WIDTH-1:0] lkp_stall_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] host_drop_count,
  output logic [1:0]                    o_dbg_s1
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = TBL_ADDR_WIDTH;
  localparam logic [7:0]    LP_LIMIT = 8'(STARVE_LIMIT);
  localparam logic [DW-1:0] LP_ONE   = DW'(1);

  typedef enum logic [1:0] {OWN_NONE, OWN_LKP, OWN_HRD, OWN_HWR} owner_e;

  owner_e          r_s1;
  owner_e          w_win;
  logic            r_wr_pend;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic            r_rd_pend;
  logic [AW-1:0]   r_rd_addr;
  logic [7:0]      r_starve_cnt;
  logic            w_host_pend;
  logic            w_force;
  logic            w_host_gnt;
  logic            w_wr_drop;
  logic            w_rd_drop;
  logic            w_soft_clr;

  // Lookup handshake: lkp_req is a level held with lkp_addr until a cycle in
  // which lkp_gnt is high; that cycle is the transfer and the result strobes
  // on lkp_valid two cycles later. lkp_gnt never depends on later cycles.
  always_comb begin
    w_host_pend = r_wr_pend | r_rd_pend;
    w_force     = w_host_pend && (r_starve_cnt == LP_LIMIT);
    w_win       = OWN_NONE;
    if (!AXI_RESETN)    w_win = OWN_NONE;
    else if (w_force)   w_win = r_wr_pend ? OWN_HWR : OWN_HRD;
    else if (lkp_req)   w_win = OWN_LKP;
    else if (r_wr_pend) w_win = OWN_HWR;
    else if (r_rd_pend) w_win = OWN_HRD;
    mem_en    = (w_win != OWN_NONE);
    mem_we    = (w_win == OWN_HWR);
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_win)
      OWN_LKP: mem_addr = lkp_addr;
      OWN_HRD: mem_addr = r_rd_addr;
      OWN_HWR: begin
        mem_addr  = r_wr_addr;
        mem_wdata = r_wr_data;
      end
      default: ;
    endcase
  end

  assign lkp_gnt    = (w_win == OWN_LKP);
  assign w_host_gnt = (w_win == OWN_HWR) || (w_win == OWN_HRD);
  // A slot freed in the same cycle it is re-requested accepts the new pulse.
  assign w_wr_drop  = tbl_wr_req && r_wr_pend && (w_win != OWN_HWR);
  assign w_rd_drop  = tbl_rd_req && r_rd_pend && (w_win != OWN_HRD);
  assign w_soft_clr = (reset == LP_ONE);
  assign tbl_wr_ack = (r_s1 == OWN_HWR);
  assign o_dbg_s1   = r_s1;

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) r_s1 <= OWN_NONE;
    else             r_s1 <= w_win;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      r_wr_pend    <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_addr    <= '0;
      r_starve_cnt <= '0;
      lkp_data     <= '0;
      lkp_valid    <= 1'b0;
      tbl_rd_data  <= '0;
      tbl_rd_ack   <= 1'b0;
    end else begin
      if (tbl_wr_req && !w_wr_drop) begin
        r_wr_pend <= 1'b1;
        r_wr_addr <= tbl_wr_addr;
        r_wr_data <= tbl_wr_data;
      end else if (w_win == OWN_HWR) begin
        r_wr_pend <= 1'b0;
      end
      if (tbl_rd_req && !w_rd_drop) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= tbl_rd_addr;
      end else if (w_win == OWN_HRD) begin
        r_rd_pend <= 1'b0;
      end
      if (w_host_gnt || !w_host_pend)
        r_starve_cnt <= '0;
      else if ((w_win == OWN_LKP) && (r_starve_cnt != LP_LIMIT))
        r_starve_cnt <= r_starve_cnt + 8'd1;
      // RAM read data is valid while s1 names its owner.
      lkp_valid  <= (r_s1 == OWN_LKP);
      tbl_rd_ack <= (r_s1 == OWN_HRD);
      if (r_s1 == OWN_LKP) lkp_data    <= mem_rdata;
      if (r_s1 == OWN_HRD) tbl_rd_data <= mem_rdata;
    end
  end

`ifdef TBL_ARB_STATS_EN
  logic [1:0] w_drop_inc;
  assign w_drop_inc = {1'b0, w_wr_drop} + {1'b0, w_rd_drop};

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN || w_soft_clr) begin
      lkp_stall_count <= '0;
      host_drop_count <= '0;
    end else begin
      if (lkp_req && !lkp_gnt)
        lkp_stall_count <= lkp_stall_count + LP_ONE;
      host_drop_count <= host_drop_count + {{(DW-2){1'b0}}, w_drop_inc};
    end
  end
`else
  logic w_stats_unused;
  assign w_stats_unused  = w_soft_clr;
  assign lkp_stall_count = '0;
  assign host_drop_count = '0;
`endif

endmodule

// File: tb/tb_router_tbl_arbiter.sv
// Bench for router_tbl_arbiter: directed scenarios plus randomized traffic against a
// latency-scheduled table model; a small synchronous RAM stands in for the table.
module tb_router_tbl_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LIMIT = 8;
  localparam int K_NONE = 0, K_LKP = 1, K_HRD = 2, K_HWR = 3;
`ifdef TBL_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          AXI_RESETN = 1'b0;
  logic [DW-1:0] reset = '0;
  logic          tbl_rd_req = 1'b0, tbl_wr_req = 1'b0;
  logic [AW-1:0] tbl_rd_addr = '0, tbl_wr_addr = '0;
  logic [DW-1:0] tbl_wr_data = '0;
  logic [DW-1:0] tbl_rd_data;
  logic          tbl_rd_ack, tbl_wr_ack;
  logic          lkp_req = 1'b0;
  logic [AW-1:0] lkp_addr = '0;
  logic          lkp_gnt;
  logic [DW-1:0] lkp_data;
  logic          lkp_valid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] lkp_stall_count, host_drop_count;
  logic [1:0]    dbg_s1_unused;

  router_tbl_arbiter #(.C_S_AXI_DATA_WIDTH(DW), .TBL_ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .AXI_ACLK(clk), .AXI_RESETN(AXI_RESETN), .reset(reset),
    .tbl_rd_req(tbl_rd_req), .tbl_wr_req(tbl_wr_req),
    .tbl_rd_addr(tbl_rd_addr), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .tbl_rd_data(tbl_rd_data), .tbl_rd_ack(tbl_rd_ack), .tbl_wr_ack(tbl_wr_ack),
    .lkp_req(lkp_req), .lkp_addr(lkp_addr), .lkp_gnt(lkp_gnt),
    .lkp_data(lkp_data), .lkp_valid(lkp_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .lkp_stall_count(lkp_stall_count), .host_drop_count(host_drop_count),
    .o_dbg_s1(dbg_s1_unused)
  );

  // Single-port synchronous table RAM.
  logic [DW-1:0] ram [32] = '{default: '0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            kind;
    logic [DW-1:0] data;
  } ev_t;

  logic [DW-1:0] m_tbl [32] = '{default: '0};
  bit            m_wr_pend, m_rd_pend;
  logic [AW-1:0] m_wr_addr, m_rd_addr;
  logic [DW-1:0] m_wr_data;
  int            m_wait;
  logic [DW-1:0] m_stall, m_drop;
  ev_t           ev_q[$];
  int            cyc;
  int            e_win;
  logic [AW-1:0] e_addr;
  bit            e_lkp_valid, e_rd_ack, e_wr_ack;
  logic [DW-1:0] e_lkp_data, e_rd_data;
  logic [DW-1:0] exp_q[$];
  int            checks, errors;

  // Mid-cycle: work out who owns the slot now and which results are due now.
  task automatic sample();
    bit host;
    @(negedge clk);
    host  = m_wr_pend || m_rd_pend;
    e_win = K_NONE;
    if (!AXI_RESETN)                 e_win = K_NONE;
    else if (host && m_wait >= LIMIT) e_win = m_wr_pend ? K_HWR : K_HRD;
    else if (lkp_req)                e_win = K_LKP;
    else if (m_wr_pend)              e_win = K_HWR;
    else if (m_rd_pend)              e_win = K_HRD;
    e_addr = (e_win == K_LKP) ? lkp_addr : (e_win == K_HRD) ? m_rd_addr : m_wr_addr;
    e_lkp_valid = 0; e_rd_ack = 0; e_wr_ack = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].due == cyc) begin
        case (ev_q[i].kind)
          K_LKP: begin e_lkp_valid = 1; e_lkp_data = ev_q[i].data; end
          K_HRD: begin e_rd_ack = 1; e_rd_data = ev_q[i].data; end
          default: e_wr_ack = 1;
        endcase
      end
    end
  endtask

  // End of cycle: apply this cycle's grant and pulses to the model, then advance.
  task automatic step();
    bit  host, drop_w, drop_r;
    ev_t keep[$];
    if (!AXI_RESETN) begin
      m_wr_pend = 0; m_rd_pend = 0; m_wait = 0;
      m_stall = '0; m_drop = '0;
      e_rd_data = '0; e_lkp_data = '0;
      ev_q.delete();
    end else begin
      host   = m_wr_pend || m_rd_pend;
      drop_w = tbl_wr_req && m_wr_pend && (e_win != K_HWR);
      drop_r = tbl_rd_req && m_rd_pend && (e_win != K_HRD);
      case (e_win)
        K_LKP: ev_q.push_back('{cyc + 2, K_LKP, m_tbl[lkp_addr]});
        K_HRD: begin ev_q.push_back('{cyc + 2, K_HRD, m_tbl[m_rd_addr]}); m_rd_pend = 0; end
        K_HWR: begin
          m_tbl[m_wr_addr] = m_wr_data;
          ev_q.push_back('{cyc + 1, K_HWR, '0});
          m_wr_pend = 0;
        end
        default: ;
      endcase
      if (e_win == K_HWR || e_win == K_HRD || !host) m_wait = 0;
      else if (e_win == K_LKP && m_wait < LIMIT)     m_wait++;
      if (tbl_wr_req && !drop_w) begin m_wr_pend = 1; m_wr_addr = tbl_wr_addr; m_wr_data = tbl_wr_data; end
      if (tbl_rd_req && !drop_r) begin m_rd_pend = 1; m_rd_addr = tbl_rd_addr; end
      if (reset == 32'd1) begin
        m_stall = '0; m_drop = '0;
      end else begin
        if (lkp_req && e_win != K_LKP) m_stall = m_stall + 32'd1;
        m_drop = m_drop + 32'(drop_w) + 32'(drop_r);
      end
      foreach (ev_q[i]) if (ev_q[i].due > cyc) keep.push_back(ev_q[i]);
      ev_q = keep;
    end
    @(posedge clk);
    #1;
    tbl_wr_req = 0;
    tbl_rd_req = 0;
    cyc++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    AXI_RESETN = 0; lkp_req = 1;
    repeat (3) begin sample(); step(); end
    sample();
    checks++;
    if ({lkp_gnt, mem_en, mem_we, lkp_valid, tbl_rd_ack, tbl_wr_ack} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
        {lkp_gnt, mem_en, mem_we, lkp_valid, tbl_rd_ack, tbl_wr_ack});
    end
    checks++;
    if ({tbl_rd_data, lkp_data, lkp_stall_count, host_drop_count} !== 128'd0) begin
      errors++; $display("FAIL reset_data: rd=%h lkp=%h stall=%0d drop=%0d want all 0",
        tbl_rd_data, lkp_data, lkp_stall_count, host_drop_count);
    end
    step();
    AXI_RESETN = 1; lkp_req = 0;
    sample(); step();
  endtask

  task automatic test_write_read();
    tbl_wr_req = 1; tbl_wr_addr = 5'd3; tbl_wr_data = 32'h0A000001;
    for (int k = 0; k <= 3; k++) begin
      sample();
      if (k == 1) begin
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 5'd3, 32'h0A000001}) begin
          errors++; $display("FAIL wr_grant: en=%b we=%b addr=%0d wdata=%h want 1 1 3 0a000001",
            mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      checks++;
      if (tbl_wr_ack !== (k == 2)) begin
        errors++; $display("FAIL wr_ack_timing: k=%0d ack=%b want %b", k, tbl_wr_ack, k == 2);
      end
      step();
    end
    tbl_rd_req = 1; tbl_rd_addr = 5'd3;
    exp_q.push_back(32'h0A000001);
    for (int k = 0; k <= 4; k++) begin
      sample();
      checks++;
      if (tbl_rd_ack !== (k == 3)) begin
        errors++; $display("FAIL rd_ack_timing: k=%0d ack=%b want %b", k, tbl_rd_ack, k == 3);
      end
      if (k == 3) begin
        checks++;
        if (tbl_rd_data !== exp_q[0]) begin
          errors++; $display("FAIL rd_data: got %h want %h", tbl_rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      step();
    end
  endtask

  task automatic test_starvation();
    logic [DW-1:0] want;
    reset = 32'd1; sample(); step(); reset = '0;
    lkp_req = 1; lkp_addr = 5'd5;
    repeat (2) begin sample(); step(); end
    want = m_tbl[9];
    tbl_rd_req = 1; tbl_rd_addr = 5'd9;
    sample(); step();
    for (int k = 1; k <= 12; k++) begin
      sample();
      checks++;
      if (lkp_gnt !== (k != 9)) begin
        errors++; $display("FAIL starve_gnt: k=%0d gnt=%b want %b", k, lkp_gnt, k != 9);
      end
      checks++;
      if (tbl_rd_ack !== (k == 11)) begin
        errors++; $display("FAIL starve_rd_ack: k=%0d ack=%b want %b", k, tbl_rd_ack, k == 11);
      end
      if (k == 11) begin
        checks++;
        if (tbl_rd_data !== want) begin
          errors++; $display("FAIL starve_rd_data: got %h want %h", tbl_rd_data, want);
        end
      end
      step();
    end
    checks++;
    if (lkp_stall_count !== (STATS ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL starve_stall_count: got %0d want %0d", lkp_stall_count, STATS ? 1 : 0);
    end
    lkp_req = 0;
    repeat (3) begin sample(); step(); end
  endtask

  task automatic test_simultaneous();
    tbl_wr_req = 1; tbl_wr_addr = 5'd7; tbl_wr_data = 32'hC0A80101;
    tbl_rd_req = 1; tbl_rd_addr = 5'd7;
    for (int k = 0; k <= 4; k++) begin
      sample();
      if (k == 1 || k == 2) begin
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, k == 1, 5'd7}) begin
          errors++; $display("FAIL simul_order: k=%0d en=%b we=%b addr=%0d want 1 %b 7",
            k, mem_en, mem_we, mem_addr, k == 1);
        end
      end
      if (k == 4) begin
        checks++;
        if ({tbl_rd_ack, tbl_rd_data} !== {1'b1, 32'hC0A80101}) begin
          errors++; $display("FAIL simul_rd: ack=%b data=%h want 1 c0a80101", tbl_rd_ack, tbl_rd_data);
        end
      end
      step();
    end
  endtask

  task automatic test_dup_drop();
    int acks;
    acks = 0;
    reset = 32'd1; sample(); step(); reset = '0;
    lkp_req = 1; lkp_addr = 5'd12;
    tbl_rd_req = 1; tbl_rd_addr = 5'd4;
    for (int k = 0; k <= 16; k++) begin
      if (k == 3) begin tbl_rd_req = 1; tbl_rd_addr = 5'd6; end
      sample();
      if (tbl_rd_ack === 1'b1) acks++;
      step();
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL dup_ack_count: got %0d want 1", acks); end
    checks++;
    if (host_drop_count !== (STATS ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL dup_drop_count: got %0d want %0d", host_drop_count, STATS ? 1 : 0);
    end
    lkp_req = 0;
    repeat (2) begin sample(); step(); end
  endtask

  task automatic test_reset_mid_read();
    tbl_rd_req = 1; tbl_rd_addr = 5'd3;
    for (int k = 0; k <= 5; k++) begin
      AXI_RESETN = (k != 2);
      sample();
      if (k == 1) begin
        checks++;
        if ({mem_en, mem_we} !== 2'b10) begin
          errors++; $display("FAIL midrd_grant: en=%b we=%b want 1 0", mem_en, mem_we);
        end
      end
      checks++;
      if (tbl_rd_ack !== 1'b0) begin errors++; $display("FAIL midrd_no_ack: k=%0d ack=%b want 0", k, tbl_rd_ack); end
      if (k == 3) begin
        checks++;
        if ({lkp_gnt, mem_en, lkp_valid, tbl_wr_ack, tbl_rd_data, lkp_data} !== 68'd0) begin
          errors++; $display("FAIL midrd_outputs: gnt=%b en=%b v=%b wack=%b rd=%h lkp=%h want all 0",
            lkp_gnt, mem_en, lkp_valid, tbl_wr_ack, tbl_rd_data, lkp_data);
        end
      end
      step();
    end
    AXI_RESETN = 1;
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 2000; n++) begin
      if (!(lkp_req && e_win != K_LKP)) begin
        lkp_req  = ($urandom_range(0, 99) < 55);
        lkp_addr = AW'($urandom_range(0, 31));
      end
      tbl_wr_req  = ($urandom_range(0, 99) < 15);
      tbl_wr_addr = AW'($urandom_range(0, 31));
      tbl_wr_data = $urandom();
      tbl_rd_req  = ($urandom_range(0, 99) < 15);
      tbl_rd_addr = AW'($urandom_range(0, 31));
      r = $urandom_range(0, 99);
      reset = (r < 2) ? 32'd1 : (r < 5) ? 32'd2 : 32'd0;
      AXI_RESETN = ($urandom_range(0, 199) != 0);
      sample();
      checks++;
      if ({lkp_gnt, mem_en, mem_we} !== {e_win == K_LKP, e_win != K_NONE, e_win == K_HWR}) begin
        errors++; $display("FAIL rnd_ctrl: cyc=%0d gnt/en/we=%b want %b", cyc, {lkp_gnt, mem_en, mem_we},
          {e_win == K_LKP, e_win != K_NONE, e_win == K_HWR});
      end
      if (e_win != K_NONE) begin
        checks++;
        if (mem_addr !== e_addr) begin
          errors++; $display("FAIL rnd_addr: cyc=%0d got %0d want %0d", cyc, mem_addr, e_addr);
        end
      end
      if (e_win == K_HWR) begin
        checks++;
        if (mem_wdata !== m_wr_data) begin
          errors++; $display("FAIL rnd_wdata: cyc=%0d got %h want %h", cyc, mem_wdata, m_wr_data);
        end
      end
      checks++;
      if ({lkp_valid, tbl_rd_ack, tbl_wr_ack} !== {e_lkp_valid, e_rd_ack, e_wr_ack}) begin
        errors++; $display("FAIL rnd_strobes: cyc=%0d lv/ra/wa=%b want %b", cyc,
          {lkp_valid, tbl_rd_ack, tbl_wr_ack}, {e_lkp_valid, e_rd_ack, e_wr_ack});
      end
      if (e_lkp_valid) begin
        checks++;
        if (lkp_data !== e_lkp_data) begin
          errors++; $display("FAIL rnd_lkp_data: cyc=%0d got %h want %h", cyc, lkp_data, e_lkp_data);
        end
      end
      checks++;
      if (tbl_rd_data !== e_rd_data) begin
        errors++; $display("FAIL rnd_rd_data: cyc=%0d got %h want %h", cyc, tbl_rd_data, e_rd_data);
      end
      checks++;
      if ({lkp_stall_count, host_drop_count} !== (STATS ? {m_stall, m_drop} : 64'd0)) begin
        errors++; $display("FAIL rnd_counters: cyc=%0d stall=%0d drop=%0d want %0d %0d", cyc,
          lkp_stall_count, host_drop_count, STATS ? m_stall : 0, STATS ? m_drop : 0);
      end
      step();
    end
    AXI_RESETN = 1; reset = '0; lkp_req = 0;
    repeat (4) begin sample(); step(); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; errors = 0; cyc = 0;
    m_wr_pend = 0; m_rd_pend = 0; m_wait = 0;
    m_wr_addr = '0; m_rd_addr = '0; m_wr_data = '0;
    m_stall = '0; m_drop = '0; e_win = K_NONE;
    e_rd_data = '0; e_lkp_data = '0;
    test_reset();
    test_write_read();
    test_starvation();
    test_simultaneous();
    test_dup_drop();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_tbl_arbiter.md
# router_tbl_arbiter

Shares the 32-entry × 32-bit destination-IP table memory between two requesters.
- The packet lookup engine in the output-port-lookup pipeline.
- The host register interface (tbl_rd_*/tbl_wr_* handshake).

The table is a single-port synchronous RAM, so only one access can issue per cycle. The lookup engine gets priority, and a starvation guard bounds host latency. The block sits between the register slave and the lookup stage and owns every table port.

## Interface
- C_S_AXI_DATA_WIDTH, 32, table word and counter width
- TBL_ADDR_WIDTH, 5, table address width (32 entries)
- STARVE_LIMIT, 8, consecutive host-wait cycles before the host is forced a slot; range 1–255
- AXI_ACLK  in  1  sole clock
- AXI_RESETN  in  1  reset; synchronous, active-low
- reset  in  32  soft counter clear when ==1
- tbl_rd_req / tbl_wr_req  in  1  one-cycle host request pulses
- tbl_rd_addr / tbl_wr_addr  in  5  host addresses
- tbl_wr_data  in  32  host write data
- tbl_rd_data  out  32  host read result
- tbl_rd_ack / tbl_wr_ack  out  1  one-cycle completion pulses
- lkp_req  in  1  lookup request level; held with lkp_addr until granted
- lkp_addr  in  5  lookup address
- lkp_gnt  out  1  combinational grant
- lkp_data  out  32  lookup result
- lkp_valid  out  1  one-cycle result strobe
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  5  RAM address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after a read
- lkp_stall_count, host_drop_count  out  32  statistics

## Operation
- **Host requests.** A request pulse latches into a pending register: wr_pend (addr + data) or rd_pend (addr).
- **Requests while pending.** A pulse arriving while the same type is pending is dropped, and host_drop_count increments. A write pulse in the same cycle that wr_pend clears is accepted.
- **Host ordering.** When both are pending, the write is serviced before the read. A read issued after a write to the same address returns the new data.
- **Grant order, evaluated each cycle:**
  1. If starve_cnt == STARVE_LIMIT and a host request is pending, the host wins.
  2. Otherwise, if lkp_req is high, the lookup wins.
  3. Otherwise, a pending host write wins.
  4. Otherwise, a pending host read wins.
  5. Otherwise, the slot is idle.
- **starve_cnt.** 8-bit counter.
  - Increments when a host request is pending and the lookup wins.
  - Clears to 0 on any host grant or when nothing is pending.
  - Saturates at STARVE_LIMIT.
- **Lookup stall.** lkp_gnt=0 while lkp_req=1 is a stall. The engine holds lkp_req and lkp_addr. lkp_stall_count increments each such cycle.
- **Memory drive.** mem_* are driven combinationally from the winner in the grant cycle. Only writes assert mem_we.
- **Pipeline owner register s1.** States NONE, LKP, HRD, HWR; loaded every cycle with the current winner. s1 routes mem_rdata and generates the acks:
  - s1=LKP: lkp_data<=mem_rdata, lkp_valid<=1.
  - s1=HRD: tbl_rd_data<=mem_rdata, tbl_rd_ack<=1.
  - s1=HWR: tbl_wr_ack<=1.
- **Counters.** Both wrap modulo 2^32. They clear on reset==1 and on AXI_RESETN=0.

## Timing
- **Lookup latency.** Grant in cycle N; lkp_valid and lkp_data in cycle N+2. Back-to-back lookups achieve one result per cycle.
- **Host write.** Pulse in cycle P; pending from P+1. Earliest grant is P+1. tbl_wr_ack one cycle after the grant.
- **Host read.** Earliest grant P+1. tbl_rd_ack and tbl_rd_data two cycles after the grant. tbl_rd_data holds until the next host read.
- **Worst-case host wait.** Under continuous lookups, a host request is granted within STARVE_LIMIT+1 cycles of becoming pending. Both reads and writes pending: the write is forced first, and the read is forced STARVE_LIMIT+1 cycles later.
- **Reset (AXI_RESETN=0).** All outputs go to 0 on the next edge. Pending registers and s1 return to NONE, and starve_cnt goes to 0. In-flight results are discarded with no ack or valid pulse.
- **Soft clear.** reset==1 clears only the counters. Arbitration continues.

## Configuration
- **TBL_ARB_STATS_EN defined:** lkp_stall_count and host_drop_count are implemented as described.
- **TBL_ARB_STATS_EN undefined:** both ports are tied to 0 and the counter logic is not synthesised. Arbitration is unchanged.

## Test plan
- **Single write then read.** tbl_wr_req addr 3, data 0x0A000001, then tbl_rd_req addr 3, no lookups. Expect tbl_wr_ack 2 cycles after the write pulse, and tbl_rd_ack with data 0x0A000001.
- **Host starvation guard.** lkp_req held high continuously, STARVE_LIMIT=8, tbl_rd_req pulse. Expect lkp_gnt=0 for exactly one cycle, 9 cycles after pending, with rd_ack 2 cycles later. lkp_stall_count=1.
- **Simultaneous write and read.** tbl_wr_req and tbl_rd_req to addr 7 in the same cycle, data 0xC0A80101. Expect the write granted first and the read returning 0xC0A80101.
- **Dropped duplicate.** Second tbl_rd_req while rd_pend is set under continuous lookups. Expect host_drop_count=1 and exactly one tbl_rd_ack.
- **Reset mid-read.** AXI_RESETN low the cycle after a host read grant. Expect no tbl_rd_ack, all outputs 0, and normal operation after release.
- **Build without TBL_ARB_STATS_EN.** Repeat the starvation scenario. Expect both counters 0 and identical grant timing.
